// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around the unified memory port arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  dm_req;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [2:0]            dm_mode;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic                  dm_valid;
    logic [DATA_WIDTH-1:0] dm_rdata;

    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [2:0]            mem_mode;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_mode, dm_wdata, mem_rdata,
        output if_valid, if_rdata, dm_valid, dm_rdata,
        output mem_en, mem_addr, mem_mode, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_mode, dm_wdata, mem_rdata,
        input  if_valid, if_rdata, dm_valid, dm_rdata,
        input  mem_en, mem_addr, mem_mode, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first with a
// starvation guard for fetch; one transaction in flight, sequenced by a small FSM.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [2:0] ModeLw    = 3'b010;
    localparam logic [2:0] StreakMax = 3'(MAX_STREAK);
    localparam logic [2:0] LatInit   = 3'(LATENCY - 1);

    // Modes 101/110/111 are SB/SH/SW.
    function automatic logic mode_is_store(logic [2:0] m);
        return m[2] & (m[1] | m[0]);
    endfunction

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;  // 1: data path, 0: fetch
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic [2:0]            streak_q, streak_d;
    logic [2:0]            lat_q, lat_d;

    logic issue;
    logic resp;
    logic if_valid;
    logic dm_valid;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        streak_d   = streak_q;
        lat_d      = lat_q;

        unique case (state_q)
            StIdle: begin
                if (bus.dm_req && ((streak_q < StreakMax) || !bus.if_req)) begin
                    owner_d = 1'b1;
                    addr_d  = bus.dm_addr;
                    mode_d  = bus.dm_mode;
                    wdata_d = mode_is_store(bus.dm_mode) ? bus.dm_wdata : '0;
                    if (bus.if_req) begin
                        streak_d = (streak_q >= StreakMax) ? StreakMax : streak_q + 3'd1;
                    end else begin
                        streak_d = 3'd0;
                    end
                    state_d = StIssue;
                end else if (bus.if_req) begin
                    owner_d  = 1'b0;
                    addr_d   = bus.if_addr;
                    mode_d   = ModeLw;
                    wdata_d  = '0;
                    streak_d = 3'd0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (owner_q && mode_is_store(mode_q)) begin
                    // Stores return no data; dm_rdata reads 0 alongside the completion pulse.
                    dm_rdata_d = '0;
                    state_d    = StResp;
                end else begin
                    lat_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q == 3'd0) begin
                    if (owner_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            mode_q     <= 3'd0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            streak_q   <= 3'd0;
            lat_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            streak_q   <= streak_d;
            lat_q      <= lat_d;
        end
    end

    assign issue    = (state_q == StIssue);
    assign resp     = (state_q == StResp);
    assign if_valid = resp & ~owner_q;
    assign dm_valid = resp & owner_q;

    // Issue fields are gated so the memory bus reads 0 between transactions.
    assign bus.mem_en    = issue;
    assign bus.mem_addr  = issue ? addr_q : '0;
    assign bus.mem_mode  = issue ? mode_q : 3'd0;
    assign bus.mem_wdata = issue ? wdata_q : '0;

    assign bus.if_valid = if_valid;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_valid = dm_valid;
    assign bus.dm_rdata = dm_rdata_q;

    assign bus.stall = (bus.if_req & ~if_valid) | (bus.dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level timing/arbitration model plus a
// word memory that answers exactly LATENCY cycles after each issue.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned MAXS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LATENCY   (LAT),
        .MAX_STREAK(MAXS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model of the transaction currently owning the port, in absolute cycle numbers.
    int          free_cyc, grant_cyc, issue_cyc, sample_cyc, valid_cyc;
    bit          own_dm, own_store;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [2:0]  t_mode;
    int          streak;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    logic [31:0] memarr [256];
    bit          release_now;
    bit          found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        grant_cyc    = -10;
        issue_cyc    = -10;
        sample_cyc   = -10;
        valid_cyc    = -10;
        free_cyc     = cyc + 1;
        streak       = 0;
        own_dm       = 1'b0;
        own_store    = 1'b0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 255)) << 2;
    endtask

    task automatic new_dm();
        bus.dm_req   = 1'b1;
        bus.dm_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.dm_mode  = 3'($urandom_range(0, 7));
        bus.dm_wdata = $urandom();
    endtask

    // Arbitration rule applied to the requests visible in an idle cycle.
    task automatic grant_decide();
        if (bus.dm_req && (streak < int'(MAXS) || !bus.if_req)) begin
            own_dm    = 1'b1;
            t_addr    = bus.dm_addr;
            t_mode    = bus.dm_mode;
            own_store = (t_mode >= 3'd5);
            t_wdata   = own_store ? bus.dm_wdata : 32'h0;
            if (bus.if_req) streak = (streak + 1 > int'(MAXS)) ? int'(MAXS) : streak + 1;
            else            streak = 0;
        end else if (bus.if_req) begin
            own_dm    = 1'b0;
            own_store = 1'b0;
            t_addr    = bus.if_addr;
            t_mode    = 3'b010;
            t_wdata   = 32'h0;
            streak    = 0;
        end else begin
            return;
        end
        grant_cyc = cyc;
        issue_cyc = cyc + 1;
        if (own_store) begin
            sample_cyc = -10;
            valid_cyc  = cyc + 2;
        end else begin
            sample_cyc = cyc + 1 + int'(LAT);
            valid_cyc  = cyc + 2 + int'(LAT);
        end
        free_cyc = valid_cyc + 1;
    endtask

    task automatic step_cycle();
        bit exp_en, exp_ifv, exp_dmv;
        @(posedge clk);
        #1;
        cyc++;
        if (release_now) begin
            rst_n       = 1'b1;
            release_now = 1'b0;
        end
        // Fetch requester: after its pulse either next request or drop; fields scrambled in flight.
        if (!own_dm && cyc == valid_cyc + 1) begin
            if ($urandom_range(0, 9) < 6) new_if();
            else bus.if_req = 1'b0;
        end else if (!bus.if_req) begin
            if ($urandom_range(0, 9) < 3) new_if();
        end else if (!own_dm && cyc > grant_cyc && cyc <= valid_cyc && $urandom_range(0, 3) == 0) begin
            bus.if_addr = $urandom();
        end
        if (own_dm && cyc == valid_cyc + 1) begin
            if ($urandom_range(0, 9) < 7) new_dm();
            else bus.dm_req = 1'b0;
        end else if (!bus.dm_req) begin
            if ($urandom_range(0, 9) < 8) new_dm();
        end else if (own_dm && cyc > grant_cyc && cyc <= valid_cyc && $urandom_range(0, 3) == 0) begin
            bus.dm_addr  = $urandom();
            bus.dm_wdata = $urandom();
            bus.dm_mode  = 3'($urandom_range(0, 7));
        end
        bus.mem_rdata = $urandom();
        if (cyc == sample_cyc) begin
            t_rdata       = memarr[t_addr[9:2]];
            bus.mem_rdata = t_rdata;
        end

        @(negedge clk);
        exp_en  = (cyc == issue_cyc);
        exp_ifv = (cyc == valid_cyc) && !own_dm;
        exp_dmv = (cyc == valid_cyc) && own_dm;
        if (exp_ifv) exp_if_rdata = t_rdata;
        if (exp_dmv) exp_dm_rdata = own_store ? 32'h0 : t_rdata;
        check("mem_en", 32'(bus.mem_en), 32'(exp_en));
        if (exp_en) begin
            check("mem_addr", bus.mem_addr, t_addr);
            check("mem_mode", 32'(bus.mem_mode), 32'(t_mode));
            check("mem_wdata", bus.mem_wdata, t_wdata);
            if (own_store) memarr[t_addr[9:2]] = t_wdata;
        end
        check("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
        check("dm_valid", 32'(bus.dm_valid), 32'(exp_dmv));
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("dm_rdata", bus.dm_rdata, exp_dm_rdata);
        check("stall", 32'(bus.stall),
              32'((bus.if_req & ~exp_ifv) | (bus.dm_req & ~exp_dmv)));
        if (cyc >= free_cyc) grant_decide();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_en"}, 32'(bus.mem_en), 32'h0);
        check({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, "_dm_valid"}, 32'(bus.dm_valid), 32'h0);
        check({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
        check({tag, "_dm_rdata"}, bus.dm_rdata, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) memarr[i] = $urandom();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_mode   = 3'd0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        release_now   = 1'b0;
        found         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_stall", 32'(bus.stall), 32'h0);
        model_reset();
        release_now = 1'b1;

        repeat (1500) step_cycle();

        // Drive to a fetch waiting on memory, then reset underneath it.
        for (int i = 0; i < 3000 && !found; i++) begin
            step_cycle();
            if (!own_dm && cyc > issue_cyc && cyc <= sample_cyc) found = 1'b1;
        end
        check("fetch_wait_reached", 32'(found), 32'h1);
        if (found) begin
            #1;
            rst_n = 1'b0;
            #1;
            check_quiet("async_rst");
            repeat (2) begin
                @(posedge clk);
                #1;
                cyc++;
                @(negedge clk);
                check_quiet("in_rst");
            end
            model_reset();
            release_now = 1'b1;
        end

        repeat (1500) step_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
